// File: rtl/display_pkg.sv
// Shared constants, FSM state type and strobe decode for the seven-segment scan capture path.
// Latency: none (package only).
// Backpressure: none (package only).
package display_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam int         NIBBLE_W   = 4;
  localparam int         IDX_W      = 3;
  localparam logic [7:0] AN_BLANK   = 8'hFF;

  typedef enum logic {
    HUNT,
    COLLECT
  } frame_state_e;

  // Result of decoding one anode sample: legal means exactly one strobe is low.
  typedef struct packed {
    logic             legal;
    logic [IDX_W-1:0] idx;
  } strobe_t;

  function automatic strobe_t decode_strobe(input logic [NUM_DIGITS-1:0] an);
    strobe_t r;
    int      zeros;
    r     = '0;
    zeros = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!an[k]) begin
        zeros = zeros + 1;
        r.idx = IDX_W'(k);
      end
    end
    r.legal = (zeros == 1);
    return r;
  endfunction

endpackage

// File: rtl/scan_settle.sv
// Synchronises the anode/nibble inputs and emits one sample strobe per stable dwell.
// Latency: 2 cycles to an_s/y_s, sample fires SETTLE cycles after an_s/y_s change.
// Backpressure: none; free-running monitor of an asynchronous scan bus.
//
// Ports:
//   clk_in, reset   clock and synchronous active-low reset
//   an, y           raw anode strobes and digit nibble (asynchronous)
//   an_s, y_s       synchronised copies
//   sample          single-cycle strobe: {an_s, y_s} has been stable long enough
module scan_settle
  import display_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [NUM_DIGITS-1:0] an,
  input  logic [NIBBLE_W-1:0]   y,
  output logic [NUM_DIGITS-1:0] an_s,
  output logic [NIBBLE_W-1:0]   y_s,
  output logic                  sample
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [NUM_DIGITS-1:0]          an_m;
  logic [NIBBLE_W-1:0]            y_m;
  logic [NUM_DIGITS+NIBBLE_W-1:0] prev;
  logic [CW-1:0]                  cnt;
  logic                           armed;
  logic                           changed;

  assign changed = ({an_s, y_s} != prev);

  // cnt == SETTLE-1 is only reachable once per dwell because cnt saturates
  // at SETTLE; armed additionally guarantees a single strobe.
  assign sample = armed && !changed && (cnt == CW'(SETTLE - 1));

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      an_m  <= AN_BLANK;
      an_s  <= AN_BLANK;
      y_m   <= '0;
      y_s   <= '0;
      prev  <= {AN_BLANK, {NIBBLE_W{1'b0}}};
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      an_m <= an;
      an_s <= an_m;
      y_m  <= y;
      y_s  <= y_m;
      prev <= {an_s, y_s};
      if (changed) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        if (cnt != CW'(SETTLE))
          cnt <= cnt + 1'b1;
        if (sample)
          armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/display_scan_capture.sv
// Rebuilds eight scanned seven-segment digits into a 32-bit word; flags bad scans and a stalled scanner.
// Latency: input change -> registered result 2 + SETTLE + 1 cycles.
// Backpressure: none; outputs are pulses/levels, the scanner is never stalled.
//
// Ports:
//   clk_in, reset   clock and synchronous active-low reset
//   an, y           anode strobes (active-low) and nibble from the display controller
//   digits          last complete frame, digit k in [4k+3:4k]
//   frame_valid     pulse when digits updates
//   frame_err       pulse on illegal strobe or out-of-order digit
//   stale           no accepted sample for TIMEOUT cycles
//   cur_idx         index of the last accepted digit
module display_scan_capture
  import display_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic [NUM_DIGITS-1:0]          an,
  input  logic [NIBBLE_W-1:0]            y,
  output logic [NUM_DIGITS*NIBBLE_W-1:0] digits,
  output logic                           frame_valid,
  output logic                           frame_err,
  output logic                           stale,
  output logic [IDX_W-1:0]               cur_idx
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [NUM_DIGITS-1:0]          an_s;
  logic [NIBBLE_W-1:0]            y_s;
  logic                           sample;
  strobe_t                        strb;

  frame_state_e                   state_q, state_d;
  logic [IDX_W-1:0]               exp_q, exp_d;
  logic [NUM_DIGITS*NIBBLE_W-1:0] shadow_q, shadow_d;
  logic                           accept;
  logic                           complete;
  logic                           err_d;
  logic [TW-1:0]                  tcnt;

  scan_settle #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk_in (clk_in),
    .reset  (reset),
    .an     (an),
    .y      (y),
    .an_s   (an_s),
    .y_s    (y_s),
    .sample (sample)
  );

  assign strb = decode_strobe(an_s);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    accept   = 1'b0;
    complete = 1'b0;
    err_d    = 1'b0;
    // Blank dwells between digits are ignored entirely.
    if (sample && (an_s != AN_BLANK)) begin
      if (!strb.legal) begin
        err_d   = 1'b1;
        state_d = HUNT;
        exp_d   = '0;
      end else begin
        case (state_q)
          HUNT: begin
            if (strb.idx == '0) begin
              shadow_d[NIBBLE_W-1:0] = y_s;
              exp_d   = IDX_W'(1);
              state_d = COLLECT;
              accept  = 1'b1;
            end
          end
          COLLECT: begin
            if (strb.idx == exp_q) begin
              shadow_d[NIBBLE_W*strb.idx +: NIBBLE_W] = y_s;
              accept = 1'b1;
              if (exp_q == IDX_W'(NUM_DIGITS - 1)) begin
                complete = 1'b1;
                exp_d    = '0;
              end else begin
                exp_d = exp_q + 1'b1;
              end
            end else if (strb.idx == '0) begin
              // A fresh digit 0 mid-frame is treated as a new frame start.
              err_d  = 1'b1;
              shadow_d[NIBBLE_W-1:0] = y_s;
              exp_d  = IDX_W'(1);
              accept = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
              exp_d   = '0;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      shadow_q    <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      cur_idx     <= '0;
      tcnt        <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      shadow_q    <= shadow_d;
      frame_valid <= complete;
      frame_err   <= err_d;
      if (complete)
        digits <= shadow_d;
      if (accept) begin
        cur_idx <= strb.idx;
        tcnt    <= '0;
      end else if (tcnt != TW'(TIMEOUT)) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  assign stale = (tcnt == TW'(TIMEOUT));

endmodule

// File: doc/display_scan_capture.md
# display_scan_capture

Receive-side counterpart of the multiplexed seven-segment scan interface. The block samples the active-low anode strobes and the 4-bit digit nibble a display controller drives, and rebuilds the eight scanned digits into a 32-bit word. It flags malformed scans and a stalled scanner. It is used as an on-board loopback and verification monitor for the display path.

## Interface
- SETTLE, 4: cycles an/y must be stable after synchronisation before a sample is taken (≥1)
- TIMEOUT, 65536: cycles without an accepted sample before `stale` asserts (≥2)
- clk_in  input  1  system clock; all logic on rising edge
- reset  input  1  reset, synchronous and active-low; one clock
- an  input  8  anode strobes, active-low; bit k selects digit k; asynchronous to clk_in
- y  input  4  digit nibble for the currently strobed anode; asynchronous to clk_in
- digits  output  32  last complete frame; digit k in bits [4k+3:4k]; reset 0
- frame_valid  output  1  one-cycle pulse when `digits` updates; reset 0
- frame_err  output  1  one-cycle pulse on illegal strobe or out-of-order digit; reset 0
- stale  output  1  level; no accepted sample for TIMEOUT cycles; reset 0
- cur_idx  output  3  index of the last accepted digit; reset 0

## Operation
- Synchronisation: `an` and `y` each pass through a 2-flop synchroniser. All further logic uses the synchronised values (an_s, y_s).
- Settle filter:
  - A counter clears whenever {an_s, y_s} differs from its previous-cycle value.
  - Otherwise the counter increments and saturates at SETTLE.
  - A sample strobe fires once, in the cycle the counter reaches SETTLE-1.
  - The `armed` flag then blocks further strobes until {an_s, y_s} changes again. One sample is taken per dwell.
- Strobe decode at sample time:
  - Exactly one zero bit in an_s: legal, idx = position of that zero.
  - 8'hFF: blank; ignored, no error, no timeout reset.
  - Any other value: illegal. Pulse frame_err, discard the partial frame, go to HUNT.
- Frame FSM, with states HUNT and COLLECT and register exp[2:0]:
  - HUNT: a legal sample with idx=0 stores y_s into shadow[3:0], sets exp=1 and moves to COLLECT. A legal sample with idx≠0 is dropped silently.
  - COLLECT, idx==exp: store y_s into shadow nibble idx. If exp==7: load `digits` from shadow (with this nibble merged), pulse frame_valid, set exp=0 (wrap), stay in COLLECT. Otherwise exp=exp+1.
  - COLLECT, idx≠exp, idx==0: pulse frame_err, restart the frame (shadow[3:0]=y_s, exp=1), stay in COLLECT.
  - COLLECT, idx≠exp, idx≠0: pulse frame_err, go to HUNT.
- An accepted (stored) sample updates cur_idx and clears the timeout counter.
- Timeout counter: increments every cycle and saturates at TIMEOUT. `stale`=1 while the count is ≥TIMEOUT. The next accepted sample clears both.
- `digits` changes only on frame completion. Partial frames never become visible.

## Timing
- An input change reaches an_s/y_s after 2 cycles. The sample strobe fires SETTLE cycles after that.
- The shadow store, cur_idx update and FSM transition happen in the cycle after the sample strobe. For digit 7, frame_valid and the `digits` update happen in that same cycle.
- frame_err is registered and asserted in the cycle after the offending sample strobe. It is a single pulse even if the illegal value persists, because `armed` blocks repeats.
- A stale timeout and an illegal-strobe frame_err in the same cycle: both asserted; they are independent.
- A glitch shorter than SETTLE cycles produces no sample.
- Reset mid-frame: FSM to HUNT, shadow, `digits`, counters and all outputs to their reset values. `armed`=1.

## Structure
- Package `display_pkg`: NUM_DIGITS=8, NIBBLE_W=4, AN_BLANK=8'hFF, FSM state enum {HUNT, COLLECT}.
- One sub-module, `scan_settle`: the 2-flop synchroniser, change detector, settle counter and armed/one-shot sample strobe. Outputs an_s, y_s and sample.
- The top module holds the strobe decode, the frame FSM, shadow/digits and the timeout counter.

## Test plan
- Clean scan: digits 0..7 strobed in order with y=1..8 for 20 cycles each -> one frame_valid, digits=32'h8765_4321, frame_err never asserted.
- Back-to-back frames: second scan with y=F,E,...,8 -> second frame_valid, digits=32'h89AB_CDEF. No gap frame is needed between scans.
- Illegal strobe: an=8'hFC mid-frame -> single frame_err pulse, digits unchanged. The next complete 0..7 scan produces frame_valid.
- Out-of-order: 0,1,2,5 -> frame_err at 5, FSM to HUNT. Digits 6,7 produce nothing. A later full 0..7 scan produces frame_valid.
- Glitch and blank: a 2-cycle an pulse and an=8'hFF dwells between digits -> no samples, no errors, frame still completes.
- Stale and reset: TIMEOUT=16 with no strobes -> stale=1 at cycle 16 after the last accept; the next accepted digit clears it. Reset asserted at digit 4 -> all outputs 0 the next cycle, and the partial frame is never emitted.
